// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle radix-4 Booth multiplier, one digit per clock, result to hi/lo
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int PW = 2*WIDTH + 2;
  localparam int IW = $clog2(WIDTH/2 + 2);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [IW-1:0] iter;
  logic [WIDTH+2:0] mr;
  logic [WIDTH+1:0] md;
  logic [PW-1:0] acc, md_ext, mag, pp, acc_next;
  logic [2:0] trip;
  logic sgn, last;
  // Booth recode of the current digit and the running sum it produces
  always_comb begin
    trip = mr[2:0];
    md_ext = {{WIDTH{md[WIDTH+1]}}, md};
    mag = (trip == 3'b011 || trip == 3'b100) ? md_ext << 1 :
          (trip == 3'b000 || trip == 3'b111) ? '0 : md_ext;
    pp = trip[2] ? -mag : mag;
    acc_next = acc + (pp << {iter, 1'b0});
    last = iter == (sgn ? IW'(WIDTH/2 - 1) : IW'(WIDTH/2));
    busy = state == RUN;
  end
  // next-state: accept start in IDLE, leave RUN after the last digit
  always_comb begin
    state_next = state;
    if (state == IDLE && start) state_next = RUN;
    if (state == RUN && last) state_next = IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= clr ? IDLE : state_next;
  // operand capture, digit accumulation and result load
  always_ff @(posedge clk) begin
    if (clr) begin
      iter <= '0;
      mr <= '0;
      md <= '0;
      acc <= '0;
      sgn <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= state == RUN && last;
      if (state == IDLE && start) begin
        md <= signed_op ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
        mr <= {(signed_op ? {{2{a[WIDTH-1]}}, a} : {2'b00, a}), 1'b0};
        sgn <= signed_op;
        acc <= '0;
        iter <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        iter <= iter + 1'b1;
        mr <= {{2{mr[WIDTH+2]}}, mr[WIDTH+2:2]};
        if (last) begin
          hi <= acc_next[2*WIDTH-1:WIDTH];
          lo <= acc_next[WIDTH-1:0];
        end
      end
    end
  end
endmodule
